// File: rtl/fp_round_pack_32.sv
// fp_round_pack_32: RNE rounding and IEEE-754 single packing, 2-stage valid/ready pipe.
// Build option FP_RP_FLAGS_EN adds the registered out_flags {ovf, unf, inexact, zero}.
module fp_round_pack_32 #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_sign,
   input  logic [MAN_W-1:0]     in_norm_m,
   input  logic [EXP_W:0]       in_norm_e,
   input  logic                 in_zero_sum,
   input  logic                 in_neg_e,
   input  logic                 in_fg,
   input  logic                 in_r,
   input  logic                 in_s,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] out_result
`ifdef FP_RP_FLAGS_EN
   ,
   output logic [3:0]           out_flags
`endif
);

   localparam logic [EXP_W:0] E_MAX = {1'b0, {EXP_W{1'b1}}};

   logic               s1_valid;
   logic               s1_sign;
   logic               s1_zero;
   logic               s1_neg;
   logic [MAN_W-1:0]   s1_m;
   logic [EXP_W:0]     s1_e;
   logic               s2_free;
   logic               s1_load;
   logic               inc;
   logic [MAN_W:0]     m_rnd;
   logic [EXP_W:0]     e_rnd;
   logic [EXP_W+MAN_W:0] res;

   assign s2_free  = ~out_valid | out_ready;
   assign in_ready = ~s1_valid | s2_free;
   assign s1_load  = in_valid & in_ready;

   // Round half to even: a bare guard bit only rounds up when the LSB is odd.
   assign inc   = in_fg & (in_r | in_s | in_norm_m[0]);
   assign m_rnd = {1'b0, in_norm_m} + {{MAN_W{1'b0}}, inc};
   assign e_rnd = {1'b0, in_norm_e[EXP_W-1:0]} + {{EXP_W{1'b0}}, m_rnd[MAN_W]};

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_zero  <= 1'b0;
         s1_neg   <= 1'b0;
         s1_m     <= '0;
         s1_e     <= '0;
      end else begin
         if (s1_load) begin
            s1_valid <= 1'b1;
            s1_sign  <= in_sign;
            s1_zero  <= in_zero_sum;
            // a set exponent MSB also means the exponent went negative
            s1_neg   <= in_neg_e | in_norm_e[EXP_W];
            s1_m     <= m_rnd[MAN_W-1:0];
            s1_e     <= e_rnd;
         end else if (s2_free) begin
            s1_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      res = {s1_sign, s1_e[EXP_W-1:0], s1_m};
      if (s1_zero || s1_neg || s1_e == '0) begin
         res = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
      end else if (s1_e >= E_MAX) begin
         res = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_result <= '0;
      end else begin
         if (s1_valid && s2_free) begin
            out_valid  <= 1'b1;
            out_result <= res;
         end else if (out_ready) begin
            out_valid  <= 1'b0;
         end
      end
   end

`ifdef FP_RP_FLAGS_EN
   logic       s1_inx;
   logic [3:0] flg;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_inx <= 1'b0;
      end else if (s1_load) begin
         s1_inx <= in_fg | in_r | in_s;
      end
   end

   always_comb begin
      flg = {2'b00, s1_inx, 1'b0};
      if (s1_zero) begin
         flg = 4'b0001;
      end else if (s1_neg || s1_e == '0) begin
         flg = {2'b01, s1_inx, 1'b1};
      end else if (s1_e >= E_MAX) begin
         flg = 4'b1010;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_flags <= 4'b0000;
      end else if (s1_valid && s2_free) begin
         out_flags <= flg;
      end
   end
`endif

endmodule

// File: tb/tb_fp_round_pack_32.sv
// tb_fp_round_pack_32: directed and randomized checks of fp_round_pack_32
// against an arithmetic round-to-nearest-even reference model.
module tb_fp_round_pack_32;

   typedef struct packed {
      logic        sign;
      logic        zs;
      logic        neg;
      logic [8:0]  e;
      logic [22:0] m;
      logic        fg;
      logic        r;
      logic        s;
   } word_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [22:0] in_norm_m;
   logic [8:0]  in_norm_e;
   logic        in_zero_sum;
   logic        in_neg_e;
   logic        in_fg;
   logic        in_r;
   logic        in_s;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [3:0]  flags_obs;

   int tests = 0;
   int fails = 0;

`ifdef FP_RP_FLAGS_EN
   logic [3:0] out_flags;
   assign flags_obs = out_flags;
`else
   assign flags_obs = 4'b0000;
`endif

   fp_round_pack_32 dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sign     (in_sign),
      .in_norm_m   (in_norm_m),
      .in_norm_e   (in_norm_e),
      .in_zero_sum (in_zero_sum),
      .in_neg_e    (in_neg_e),
      .in_fg       (in_fg),
      .in_r        (in_r),
      .in_s        (in_s),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
`ifdef FP_RP_FLAGS_EN
      .out_flags   (out_flags),
`endif
      .out_result  (out_result)
   );

   always #5 clk = ~clk;

   task automatic apply(input word_t w);
      in_sign     = w.sign;
      in_zero_sum = w.zs;
      in_neg_e    = w.neg;
      in_norm_e   = w.e;
      in_norm_m   = w.m;
      in_fg       = w.fg;
      in_r        = w.r;
      in_s        = w.s;
   endtask

   // Reference: remainder below the LSB compared against one half, ties to even.
   function automatic logic [35:0] model(input word_t w);
      int unsigned mant;
      int unsigned ex;
      bit          up;
      bit          half;
      bit          above;
      bit          inexact;
      logic [31:0] res;
      logic [3:0]  fl;
      half    = w.fg && !w.r && !w.s;
      above   = w.fg && (w.r || w.s);
      inexact = w.fg || w.r || w.s;
      up      = above || (half && (w.m % 2 == 1));
      mant    = w.m + (up ? 1 : 0);
      ex      = w.e % 256;
      if (mant == 32'd8388608) begin
         mant = 0;
         ex   = ex + 1;
      end
      if (w.zs) begin
         res = {w.sign, 31'd0};
         fl  = 4'b0001;
      end else if (w.neg || ex == 0) begin
         res = {w.sign, 31'd0};
         fl  = {2'b01, inexact, 1'b1};
      end else if (ex >= 255) begin
         res = {w.sign, 8'hFF, 23'd0};
         fl  = 4'b1010;
      end else begin
         res = {w.sign, ex[7:0], mant[22:0]};
         fl  = {2'b00, inexact, 1'b0};
      end
      return {res, fl};
   endfunction

   function automatic word_t rand_word();
      word_t w;
      w.sign = 1'($urandom_range(0, 1));
      w.zs   = ($urandom_range(0, 15) == 0);
      w.neg  = ($urandom_range(0, 15) == 0);
      w.m    = 23'($urandom);
      if ($urandom_range(0, 7) == 0) w.m = '1;
      case ($urandom_range(0, 7))
         0: w.e = 9'd254;
         1: w.e = 9'd0;
         2: w.e = 9'd1;
         3: w.e = 9'd253;
         default: w.e = {1'b0, 8'($urandom)};
      endcase
      if (w.neg) w.e = {1'b1, 8'($urandom)};
      w.fg = 1'($urandom_range(0, 1));
      w.r  = 1'($urandom_range(0, 1));
      w.s  = 1'($urandom_range(0, 1));
      return w;
   endfunction

   function automatic word_t mk(input logic sg, input logic zs, input logic ng,
                                input logic [8:0] e, input logic [22:0] m,
                                input logic fg, input logic r, input logic s);
      word_t w;
      w.sign = sg; w.zs = zs; w.neg = ng; w.e = e; w.m = m;
      w.fg = fg; w.r = r; w.s = s;
      return w;
   endfunction

   task automatic idle_inputs();
      in_valid = 1'b0;
      apply('0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      tests++;
      if (out_valid !== 1'b0 || out_result !== 32'h0) begin
         fails++;
         $display("FAIL reset_out: valid=%b result=%h, required valid=0 result=0",
                  out_valid, out_result);
      end
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      end
`ifdef FP_RP_FLAGS_EN
      tests++;
      if (out_flags !== 4'b0000) begin
         fails++;
         $display("FAIL reset_flags: got %b, required 0000", out_flags);
      end
`endif
   endtask

   // Presents one word with the output side open and measures cycles to out_valid.
   task automatic send_wait(input word_t w, output logic [31:0] r,
                            output logic [3:0] f, output int lat);
      @(negedge clk);
      apply(w);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      lat = 0;
      r = 'x;
      f = 'x;
      while (lat < 10) begin
         @(negedge clk);
         in_valid = 1'b0;
         lat++;
         #1;
         if (out_valid === 1'b1) begin
            r = out_result;
            f = flags_obs;
            break;
         end
      end
   endtask

   task automatic test_directed();
      word_t       w[8];
      logic [31:0] er[8];
      logic [3:0]  ef[8];
      logic [31:0] r;
      logic [3:0]  f;
      int          lat;
      w[0] = mk(0, 0, 0, 9'h07F, 23'h000000, 1, 0, 0); er[0] = 32'h3F800000; ef[0] = 4'b0010;
      w[1] = mk(0, 0, 0, 9'h07F, 23'h7FFFFF, 1, 0, 1); er[1] = 32'h40000000; ef[1] = 4'b0010;
      w[2] = mk(0, 0, 0, 9'h0FE, 23'h7FFFFF, 1, 0, 1); er[2] = 32'h7F800000; ef[2] = 4'b1010;
      w[3] = mk(1, 1, 0, 9'h07F, 23'h123456, 0, 0, 0); er[3] = 32'h80000000; ef[3] = 4'b0001;
      w[4] = mk(0, 0, 1, 9'h1FF, 23'h000000, 0, 0, 0); er[4] = 32'h00000000; ef[4] = 4'b0101;
      w[5] = mk(0, 0, 0, 9'h07F, 23'h000001, 1, 0, 0); er[5] = 32'h3F800002; ef[5] = 4'b0010;
      w[6] = mk(1, 0, 0, 9'h07F, 23'h000001, 0, 1, 1); er[6] = 32'hBF800001; ef[6] = 4'b0010;
      w[7] = mk(0, 0, 0, 9'h000, 23'h000010, 0, 0, 0); er[7] = 32'h00000000; ef[7] = 4'b0101;
      for (int i = 0; i < 8; i++) begin
         send_wait(w[i], r, f, lat);
         tests++;
         if (r !== er[i]) begin
            fails++;
            $display("FAIL directed_%0d_result: got %h, required %h", i, r, er[i]);
         end
         tests++;
         if (lat != 2) begin
            fails++;
            $display("FAIL directed_%0d_latency: got %0d, required 2", i, lat);
         end
`ifdef FP_RP_FLAGS_EN
         tests++;
         if (f !== ef[i]) begin
            fails++;
            $display("FAIL directed_%0d_flags: got %b, required %b", i, f, ef[i]);
         end
`endif
      end
   endtask

   task automatic test_back_to_back();
      logic [35:0] exq[$];
      word_t       w;
      int          sent = 0;
      int          got = 0;
      int          cyc = 0;
      int          dups = 0;
      w = rand_word();
      while (got < 8 && cyc < 40) begin
         @(negedge clk);
         in_valid  = (sent < 8);
         apply(w);
         out_ready = !(cyc >= 4 && cyc <= 6);
         #1;
         if (cyc >= 4 && cyc <= 6) begin
            tests++;
            if (in_ready !== 1'b0) begin
               fails++;
               $display("FAIL b2b_in_ready_full: cycle %0d got %b, required 0", cyc, in_ready);
            end
         end
         if (in_valid && in_ready) begin
            exq.push_back(model(w));
            sent++;
            w = rand_word();
         end
         if (out_valid && out_ready) begin
            tests++;
            if (exq.size() == 0) begin
               fails++;
               $display("FAIL b2b_extra: unexpected word %h, required none", out_result);
            end else if (out_result !== exq[0][35:4]) begin
               fails++;
               $display("FAIL b2b_word_%0d: got %h, required %h", got, out_result, exq[0][35:4]);
            end
            if (exq.size() != 0) void'(exq.pop_front());
            got++;
         end
         cyc++;
      end
      tests++;
      if (got != 8) begin
         fails++;
         $display("FAIL b2b_count: got %0d words, required 8", got);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1;
         if (out_valid) dups++;
      end
      tests++;
      if (dups != 0) begin
         fails++;
         $display("FAIL b2b_duplicate: got %0d trailing valid cycles, required 0", dups);
      end
   endtask

   task automatic test_reset_mid();
      int stale = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         apply(rand_word());
         in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid_valid: got %b, required 0", out_valid);
      end
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (5) begin
         @(negedge clk);
         #1;
         if (out_valid !== 1'b0) stale++;
      end
      tests++;
      if (stale != 0) begin
         fails++;
         $display("FAIL rst_mid_stale: got %0d valid cycles, required 0", stale);
      end
   endtask

   task automatic test_random();
      localparam int N = 10000;
      logic [35:0] exq[$];
      word_t       w;
      int          sent = 0;
      int          got = 0;
      int          cyc = 0;
      int          bad = 0;
      int          unstable = 0;
      logic        held_v = 1'b0;
      logic [31:0] held_r = '0;
      logic [3:0]  held_f = '0;
      w = rand_word();
      while (got < N && cyc < 4 * N) begin
         @(negedge clk);
         if (held_v && (out_valid !== 1'b1 || out_result !== held_r || flags_obs !== held_f)) begin
            unstable++;
            if (unstable < 5)
               $display("FAIL rand_hold: got v=%b %h, required held %h", out_valid, out_result, held_r);
         end
         in_valid  = (sent < N) && ($urandom_range(0, 3) != 0);
         apply(w);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (in_valid && in_ready) begin
            exq.push_back(model(w));
            sent++;
            w = rand_word();
         end
         if (out_valid && out_ready) begin
            tests++;
            if (exq.size() == 0 || out_result !== exq[0][35:4]
`ifdef FP_RP_FLAGS_EN
                || out_flags !== exq[0][3:0]
`endif
               ) begin
               fails++;
               bad++;
               if (bad < 10)
                  $display("FAIL rand_word_%0d: got %h/%b, required %h/%b", got,
                           out_result, flags_obs, exq.size() ? exq[0][35:4] : 32'h0,
                           exq.size() ? exq[0][3:0] : 4'h0);
            end
            if (exq.size() != 0) void'(exq.pop_front());
            got++;
         end
         held_v = out_valid && !out_ready;
         held_r = out_result;
         held_f = flags_obs;
         cyc++;
      end
      in_valid = 1'b0;
      tests++;
      if (got != N) begin
         fails++;
         $display("FAIL rand_timeout: got %0d words, required %0d", got, N);
      end
      tests++;
      if (unstable != 0) begin
         fails++;
         $display("FAIL rand_stall_stability: got %0d changes, required 0", unstable);
      end
   endtask

   initial begin
      rst = 1'b1;
      out_ready = 1'b1;
      idle_inputs();
      test_reset();
      test_directed();
      do_reset();
      test_back_to_back();
      do_reset();
      test_reset_mid();
      do_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
